// File: rtl/sad2_stage_pkg.sv
// Shared types and constants for the SAD2 accumulation stage.
// Holds the FSM encoding, the length limit and the best-SAD reset value.
package sad2_stage_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam logic [4:0]  MaxLen   = 5'd16;
   localparam logic [31:0] BestInit = 32'hFFFF_FFFF;

   // Requests longer than the word buffer are clamped rather than rejected.
   function automatic logic [4:0] clamp_len(input logic [4:0] len);
      return (len > MaxLen) ? MaxLen : len;
   endfunction

endpackage

// File: rtl/sad_byte4.sv
// Sum of absolute differences over the four unsigned bytes of a word pair.
// Purely combinational; the result fits in 10 bits (4 * 255 = 1020).
module sad_byte4 (
   input  logic [31:0] frame,
   input  logic [31:0] window,
   output logic [9:0]  sum
);

   logic [7:0] diff;

   always_comb begin
      sum  = '0;
      diff = '0;
      for (int i = 0; i < 4; i++) begin
         if (frame[8*i +: 8] >= window[8*i +: 8]) begin
            diff = frame[8*i +: 8] - window[8*i +: 8];
         end else begin
            diff = window[8*i +: 8] - frame[8*i +: 8];
         end
         sum = sum + {2'b00, diff};
      end
   end

endmodule

// File: rtl/sad2_stage.sv
// SAD accumulation stage: sums byte absolute differences over up to 16 word
// pairs, reports the result, and tracks the minimum SAD with its operation ordinal.
module sad2_stage
   import sad2_stage_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        StartSAD2,
   input  logic [4:0]  LengthSAD2,
   input  logic [31:0] FrameWordSAD2,
   input  logic [31:0] WindowWordSAD2,
   input  logic        WordValidSAD2,
   input  logic        ClearBestSAD2,
   output logic [31:0] SADResultSAD2,
   output logic        SADDoneSAD2,
   output logic [31:0] BestSADSAD2,
   output logic [7:0]  BestIndexSAD2,
   output logic        StallSAD2
);

   state_e      state_q, state_d;
   logic [13:0] acc_q;
   logic [13:0] acc_next;
   logic [4:0]  cnt_q;
   logic [4:0]  len_q;
   logic [31:0] result_q;
   logic [31:0] best_q;
   logic [7:0]  best_idx_q;
   logic [7:0]  op_cnt_q;
   logic [9:0]  word_sad;
   logic        consume;
   logic        last_word;

   sad_byte4 u_sad_byte4 (
      .frame  (FrameWordSAD2),
      .window (WindowWordSAD2),
      .sum    (word_sad)
   );

   assign consume   = (state_q == StAccum) && WordValidSAD2;
   assign last_word = consume && ((cnt_q + 5'd1) == len_q);
   assign acc_next  = acc_q + {4'd0, word_sad};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (StartSAD2) begin
               state_d = (LengthSAD2 == 5'd0) ? StDone : StAccum;
            end
         end
         StAccum: begin
            if (last_word) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      SADDoneSAD2 = (state_q == StDone);
      StallSAD2   = (state_q != StIdle);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         result_q   <= '0;
         best_q     <= BestInit;
         best_idx_q <= '0;
         op_cnt_q   <= '0;
      end else begin
         if ((state_q == StIdle) && StartSAD2) begin
            len_q <= clamp_len(LengthSAD2);
            acc_q <= '0;
            cnt_q <= '0;
            if (LengthSAD2 == 5'd0) begin
               result_q <= '0;
            end
         end
         if (consume) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 5'd1;
            if (last_word) begin
               result_q <= {18'd0, acc_next};
            end
         end
         // Clearing wins over the DONE update; that result is never compared.
         if (ClearBestSAD2) begin
            best_q     <= BestInit;
            best_idx_q <= '0;
            op_cnt_q   <= '0;
         end else if (state_q == StDone) begin
            if (result_q < best_q) begin
               best_q     <= result_q;
               best_idx_q <= op_cnt_q;
            end
            op_cnt_q <= op_cnt_q + 8'd1;
         end
      end
   end

   assign SADResultSAD2 = result_q;
   assign BestSADSAD2   = best_q;
   assign BestIndexSAD2 = best_idx_q;

endmodule

// File: tb/tb_sad2_stage.sv
// Directed bench for sad2_stage: latency, SAD values, stall, clamping,
// best tracking with ties and clear, and reset abort.
module tb_sad2_stage;

   logic        Clk;
   logic        Reset;
   logic        StartSAD2;
   logic [4:0]  LengthSAD2;
   logic [31:0] FrameWordSAD2;
   logic [31:0] WindowWordSAD2;
   logic        WordValidSAD2;
   logic        ClearBestSAD2;
   logic [31:0] SADResultSAD2;
   logic        SADDoneSAD2;
   logic [31:0] BestSADSAD2;
   logic [7:0]  BestIndexSAD2;
   logic        StallSAD2;

   int          checks;
   int          errors;
   logic [31:0] fw [16];
   logic [31:0] ww [16];
   int          done_cyc;
   logic [31:0] res;
   logic        stall_ok;
   logic        saw_done;

   sad2_stage dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .StartSAD2      (StartSAD2),
      .LengthSAD2     (LengthSAD2),
      .FrameWordSAD2  (FrameWordSAD2),
      .WindowWordSAD2 (WindowWordSAD2),
      .WordValidSAD2  (WordValidSAD2),
      .ClearBestSAD2  (ClearBestSAD2),
      .SADResultSAD2  (SADResultSAD2),
      .SADDoneSAD2    (SADDoneSAD2),
      .BestSADSAD2    (BestSADSAD2),
      .BestIndexSAD2  (BestIndexSAD2),
      .StallSAD2      (StallSAD2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts an operation and feeds fw/ww; a gap of gap_len idle cycles follows word gap_at.
   task automatic run_op(input logic [4:0] len, input int nwords, input int gap_at,
                         input int gap_len, input logic clr_at_done);
      int w;
      int gap;
      int cyc;
      w        = 0;
      gap      = 0;
      cyc      = 0;
      done_cyc = -1;
      stall_ok = 1'b1;
      res      = '0;
      @(negedge Clk);
      StartSAD2     = 1'b1;
      LengthSAD2    = len;
      WordValidSAD2 = 1'b0;
      while (cyc < 40 && done_cyc < 0) begin
         @(negedge Clk);
         cyc++;
         StartSAD2 = 1'b0;
         if (StallSAD2 !== 1'b1) stall_ok = 1'b0;
         if (SADDoneSAD2 === 1'b1) begin
            done_cyc      = cyc;
            res           = SADResultSAD2;
            WordValidSAD2 = 1'b0;
            ClearBestSAD2 = clr_at_done;
         end else if (gap > 0) begin
            WordValidSAD2 = 1'b0;
            gap--;
         end else if (w < nwords) begin
            WordValidSAD2  = 1'b1;
            FrameWordSAD2  = fw[w];
            WindowWordSAD2 = ww[w];
            if (w == gap_at) gap = gap_len;
            w++;
         end else begin
            WordValidSAD2 = 1'b0;
         end
      end
      @(negedge Clk);
      ClearBestSAD2 = 1'b0;
   endtask

   task automatic single(input logic [31:0] f, input logic clr);
      fw[0] = f;
      ww[0] = 32'h0;
      run_op(5'd1, 1, -1, 0, clr);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      Reset          = 1'b1;
      StartSAD2      = 1'b0;
      LengthSAD2     = '0;
      FrameWordSAD2  = '0;
      WindowWordSAD2 = '0;
      WordValidSAD2  = 1'b0;
      ClearBestSAD2  = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_result", SADResultSAD2, 32'h0);
      check("rst_done", {31'd0, SADDoneSAD2}, 32'h0);
      check("rst_stall", {31'd0, StallSAD2}, 32'h0);
      check("rst_best", BestSADSAD2, 32'hFFFF_FFFF);
      check("rst_idx", {24'd0, BestIndexSAD2}, 32'h0);
      Reset = 1'b0;

      // Length 0: done next cycle, result 0 becomes best at ordinal 0.
      run_op(5'd0, 0, -1, 0, 1'b0);
      check("len0_cyc", done_cyc, 32'd1);
      check("len0_res", res, 32'd0);
      check("len0_best", BestSADSAD2, 32'd0);
      check("len0_idx", {24'd0, BestIndexSAD2}, 32'd0);

      fw[0] = 32'h0A14_1E28;
      ww[0] = 32'h0519_1E00;
      run_op(5'd1, 1, -1, 0, 1'b0);
      check("len1_cyc", done_cyc, 32'd2);
      check("len1_res", res, 32'd50);
      check("len1_stall", {31'd0, stall_ok}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         fw[i] = 32'hFFFF_FFFF;
         ww[i] = 32'h0;
      end
      run_op(5'd16, 16, -1, 0, 1'b0);
      check("len16_cyc", done_cyc, 32'd17);
      check("len16_res", res, 32'h3FC0);
      check("idle_stall", {31'd0, StallSAD2}, 32'd0);

      // 160 + 4 + 4 with two idle cycles after the first word.
      fw[0] = 32'h1020_3040; ww[0] = 32'h0000_0000;
      fw[1] = 32'h0000_0000; ww[1] = 32'h0101_0101;
      fw[2] = 32'h8080_8080; ww[2] = 32'h7F81_7F81;
      run_op(5'd3, 3, 0, 2, 1'b0);
      check("gap_cyc", done_cyc, 32'd6);
      check("gap_res", res, 32'd168);
      check("gap_stall", {31'd0, stall_ok}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         fw[i] = 32'h0100_0000;
         ww[i] = 32'h0;
      end
      run_op(5'd20, 16, -1, 0, 1'b0);
      check("clamp_cyc", done_cyc, 32'd17);
      check("clamp_res", res, 32'd16);

      @(negedge Clk);
      ClearBestSAD2 = 1'b1;
      @(negedge Clk);
      ClearBestSAD2 = 1'b0;
      check("clr_best", BestSADSAD2, 32'hFFFF_FFFF);
      check("clr_idx", {24'd0, BestIndexSAD2}, 32'd0);

      single(32'h0000_0064, 1'b0);
      check("b0_best", BestSADSAD2, 32'd100);
      single(32'h0000_0028, 1'b0);
      check("b1_idx", {24'd0, BestIndexSAD2}, 32'd1);
      single(32'h0000_0028, 1'b0);
      check("tie_idx", {24'd0, BestIndexSAD2}, 32'd1);
      single(32'h0000_0046, 1'b0);
      check("b3_best", BestSADSAD2, 32'd40);
      check("b3_idx", {24'd0, BestIndexSAD2}, 32'd1);
      single(32'h0000_000A, 1'b1);
      check("clrdone_res", res, 32'd10);
      check("clrdone_best", BestSADSAD2, 32'hFFFF_FFFF);
      check("clrdone_idx", {24'd0, BestIndexSAD2}, 32'd0);
      single(32'h0000_0046, 1'b0);
      check("after_clr_best", BestSADSAD2, 32'd70);
      check("after_clr_idx", {24'd0, BestIndexSAD2}, 32'd0);

      // Reset lands together with the second word of a length-4 operation.
      @(negedge Clk);
      StartSAD2  = 1'b1;
      LengthSAD2 = 5'd4;
      @(negedge Clk);
      StartSAD2      = 1'b0;
      WordValidSAD2  = 1'b1;
      FrameWordSAD2  = 32'hFFFF_FFFF;
      WindowWordSAD2 = 32'h0;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset         = 1'b0;
      WordValidSAD2 = 1'b1;
      saw_done      = 1'b0;
      check("abort_stall", {31'd0, StallSAD2}, 32'd0);
      check("abort_res", SADResultSAD2, 32'd0);
      repeat (5) begin
         @(negedge Clk);
         if (SADDoneSAD2 === 1'b1) saw_done = 1'b1;
      end
      WordValidSAD2 = 1'b0;
      check("abort_nodone", {31'd0, saw_done}, 32'd0);
      check("abort_idle_stall", {31'd0, StallSAD2}, 32'd0);
      single(32'h0000_0005, 1'b0);
      check("post_rst_res", res, 32'd5);
      check("post_rst_cyc", done_cyc, 32'd2);
      check("post_rst_idx", {24'd0, BestIndexSAD2}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
